dmem_responder: RTL and testbench

//  Data-memory responder for the pipelined processor's dmem port: serves address_dmem/data/wren and returns q_dmem.

---
 rtl/dmem_responder.sv | 99 +++++++++
 tb/tb_dmem_responder.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus an MMIO window (cycle counter, TX byte FIFO, LEDs).
// All state moves on the falling clock edge so loads resolve within the processor's M cycle.
module dmem_responder #(
    parameter int          ADDR_BITS  = 12,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'h0000_FFF0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [15:0] leds
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   mem [0:(1 << ADDR_BITS) - 1];
    logic [7:0]    fifo [0:FIFO_DEPTH - 1];
    logic [31:0]   cycle;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic          overflow;

    logic          is_ram;
    logic          is_cyc;
    logic          is_tx;
    logic          is_led;
    logic          is_clr;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push_req;
    logic          push;
    logic [CW-1:0] count_next;
    logic [31:0]   status;
    logic [31:0]   rdata;

    // Full 32-bit decode; anything outside RAM and the four MMIO words reads as zero.
    assign is_ram = (address_dmem >> ADDR_BITS) == 32'd0;
    assign is_cyc = address_dmem == MMIO_BASE;
    assign is_tx  = address_dmem == MMIO_BASE + 32'd1;
    assign is_led = address_dmem == MMIO_BASE + 32'd2;
    assign is_clr = address_dmem == MMIO_BASE + 32'd3;

    assign empty      = count == '0;
    assign full       = count == CW'(FIFO_DEPTH);
    assign pop        = tx_valid & tx_ready;
    assign push_req   = wren & is_tx;
    // A push into a full FIFO still lands when the head leaves on the same edge.
    assign push       = push_req & (~full | pop);
    assign count_next = count + CW'(push) - CW'(pop);
    assign status     = {20'd0, 8'(count), 1'b0, overflow, full, empty};
    assign tx_data    = fifo[head];

    always_comb begin
        rdata = 32'd0;
        if (is_ram)      rdata = mem[address_dmem[ADDR_BITS-1:0]];
        else if (is_cyc) rdata = cycle;
        else if (is_tx)  rdata = status;
        else if (is_led) rdata = {16'd0, leds};
    end

    // RAM contents survive reset; only the store itself is suppressed.
    always_ff @(negedge clock) begin
        if (!reset && wren && is_ram)
            mem[address_dmem[ADDR_BITS-1:0]] <= data;
        if (!reset && push)
            fifo[tail] <= data[7:0];
    end

    always_ff @(negedge clock) begin
        if (reset) begin
            q_dmem   <= 32'd0;
            cycle    <= 32'd0;
            leds     <= 16'd0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            tx_valid <= 1'b0;
            overflow <= 1'b0;
        end else begin
            q_dmem   <= rdata;
            cycle    <= (wren && is_cyc) ? data : cycle + 32'd1;
            if (wren && is_led) leds <= data[15:0];
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            count    <= count_next;
            tx_valid <= count_next != '0;
            if (push_req && full && !pop) overflow <= 1'b1;
            else if (wren && is_clr)      overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM, MMIO registers, TX FIFO and reset behaviour.
module tb_dmem_responder;
    localparam logic [31:0] BASE = 32'h0000_FFF0;

    logic        clock;
    logic        reset;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] leds;

    int checks = 0;
    int errors = 0;

    dmem_responder #(.ADDR_BITS(12), .FIFO_DEPTH(8), .MMIO_BASE(BASE)) dut (
        .clock(clock), .reset(reset), .address_dmem(address_dmem), .data(data),
        .wren(wren), .q_dmem(q_dmem), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .leds(leds)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one request, let the falling edge take it, then settle past the edge.
    task automatic go(input logic [31:0] a, input logic [31:0] d, input logic we);
        address_dmem = a;
        data         = d;
        wren         = we;
        @(negedge clock);
        #1;
    endtask

    initial begin
        logic [7:0] exp4 [0:7];
        reset = 1'b0; address_dmem = 32'd0; data = 32'd0; wren = 1'b0; tx_ready = 1'b0;

        go(32'd6, 32'h1234_5678, 1'b1);
        reset = 1'b1;
        go(32'd0, 32'd0, 1'b0);
        go(32'd0, 32'd0, 1'b0);
        chk("rst_q", q_dmem, 32'd0);
        chk("rst_txv", {31'd0, tx_valid}, 32'd0);
        chk("rst_leds", {16'd0, leds}, 32'd0);
        reset = 1'b0;

        go(BASE, 32'd0, 1'b0);
        chk("cyc_after_rst", q_dmem, 32'd0);
        go(BASE, 32'd0, 1'b0);
        chk("cyc_inc", q_dmem, 32'd1);

        go(32'd5, 32'hDEAD_BEEF, 1'b1);
        go(32'd5, 32'd0, 1'b0);
        chk("ram_wr_rd", q_dmem, 32'hDEAD_BEEF);
        go(32'd6, 32'd0, 1'b0);
        chk("ram_kept_rst", q_dmem, 32'h1234_5678);

        go(32'd7, 32'h22, 1'b1);
        go(32'd7, 32'h11, 1'b1);
        chk("rbw_old", q_dmem, 32'h22);
        go(32'd7, 32'd0, 1'b0);
        chk("rbw_new", q_dmem, 32'h11);

        go(BASE + 32'd2, 32'hABCD_1234, 1'b1);
        chk("leds_wr", {16'd0, leds}, 32'h1234);
        go(BASE + 32'd2, 32'd0, 1'b0);
        chk("leds_rd", q_dmem, 32'h0000_1234);

        for (int i = 1; i <= 9; i++) go(BASE + 32'd1, 32'(i), 1'b1);
        go(BASE + 32'd1, 32'd0, 1'b0);
        chk("status_ovf", q_dmem, 32'h086);
        chk("txv_full", {31'd0, tx_valid}, 32'd1);
        tx_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            chk("drain_valid", {31'd0, tx_valid}, 32'd1);
            chk("drain_byte", {24'd0, tx_data}, 32'(k));
            go(32'd0, 32'd0, 1'b0);
        end
        chk("txv_fall", {31'd0, tx_valid}, 32'd0);
        go(BASE + 32'd1, 32'd0, 1'b0);
        chk("status_sticky", q_dmem, 32'h005);
        go(BASE + 32'd3, 32'd0, 1'b1);
        go(BASE + 32'd1, 32'd0, 1'b0);
        chk("status_clr", q_dmem, 32'h001);

        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) go(BASE + 32'd1, 32'h10 + 32'(i), 1'b1);
        tx_ready = 1'b1;
        chk("full_head", {24'd0, tx_data}, 32'h10);
        go(BASE + 32'd1, 32'hAA, 1'b1);
        tx_ready = 1'b0;
        go(BASE + 32'd1, 32'd0, 1'b0);
        chk("status_pushpop", q_dmem, 32'h082);
        exp4 = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'hAA};
        tx_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("pp_byte", {24'd0, tx_data}, {24'd0, exp4[k]});
            go(32'd0, 32'd0, 1'b0);
        end
        chk("pp_empty", {31'd0, tx_valid}, 32'd0);
        tx_ready = 1'b0;

        go(BASE, 32'hFFFF_FFFE, 1'b1);
        go(BASE, 32'd0, 1'b0);
        chk("cyc_load", q_dmem, 32'hFFFF_FFFE);
        go(BASE, 32'd0, 1'b0);
        chk("cyc_max", q_dmem, 32'hFFFF_FFFF);
        go(BASE, 32'd0, 1'b0);
        chk("cyc_wrap", q_dmem, 32'd0);

        for (int i = 0; i < 3; i++) go(BASE + 32'd1, 32'h40 + 32'(i), 1'b1);
        chk("pre_rst_txv", {31'd0, tx_valid}, 32'd1);
        reset = 1'b1;
        go(BASE + 32'd1, 32'h55, 1'b1);
        chk("rst2_txv", {31'd0, tx_valid}, 32'd0);
        chk("rst2_leds", {16'd0, leds}, 32'd0);
        chk("rst2_q", q_dmem, 32'd0);
        reset = 1'b0;
        go(BASE + 32'd1, 32'd0, 1'b0);
        chk("rst2_status", q_dmem, 32'h001);
        go(BASE + 32'd4, 32'd0, 1'b0);
        chk("unmapped_fff4", q_dmem, 32'd0);
        go(32'h8000_0000, 32'd0, 1'b0);
        chk("unmapped_hi", q_dmem, 32'd0);
        go(BASE + 32'd3, 32'd0, 1'b0);
        chk("clr_rd", q_dmem, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
